// File: rtl/instr_encoder.sv
// Packs structured RV32I instruction requests into 32-bit words, buffers them in a
// small FIFO and streams them to instruction memory at consecutive byte addresses.
module instr_encoder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when the upper bits of v, from bit msb upward, are a pure sign extension.
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned msb);
    logic all_one;
    logic all_zero;
    all_one  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i >= msb) begin
        all_one  = all_one & v[i];
        all_zero = all_zero & ~v[i];
      end else begin
        all_one  = all_one;
        all_zero = all_zero;
      end
    end
    return all_one | all_zero;
  endfunction

  // Returns {error, word}; an out-of-range immediate or illegal format yields a NOP.
  function automatic logic [32:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        bad;
    w   = 32'h0000_0000;
    bad = 1'b0;
    case (fmt)
      3'd0: w = {f7, rs2, rs1, f3, rd, op};
      3'd1: begin
        w   = {imm[11:0], rs1, f3, rd, op};
        bad = ~sext_ok(imm, 11);
      end
      3'd2: begin
        w   = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        bad = ~sext_ok(imm, 11);
      end
      3'd3: begin
        w   = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        bad = ~sext_ok(imm, 12) | imm[0];
      end
      3'd4: begin
        w   = {imm[31:12], rd, op};
        bad = (imm[11:0] != 12'h000);
      end
      3'd5: begin
        w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        bad = ~sext_ok(imm, 20) | imm[0];
      end
      default: bad = 1'b1;
    endcase
    return bad ? {1'b1, NOP_WORD} : {1'b0, w};
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [31:0]        mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wptr_r;
  logic [PTR_W-1:0]   rptr_r;
  logic [PTR_W:0]     occ_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [15:0]        count_r;
  logic               err_r;
  logic               full_s;
  logic               empty_s;
  logic               push_s;
  logic               pop_s;
  logic               begin_s;
  logic [32:0]        enc_s;

  assign full_s  = (occ_r == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty_s = (occ_r == {(PTR_W + 1){1'b0}});
  assign in_ready = (state_r == ST_RUN) && !full_s;
  assign push_s  = in_valid && in_ready;
  assign pop_s   = !empty_s && wr_ready;
  assign begin_s = (state_r == ST_IDLE) && start;
  assign enc_s   = encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);

  assign wr_en   = !empty_s;
  assign wr_data = empty_s ? 32'h0000_0000 : mem_r[rptr_r];
  assign wr_addr = addr_r;
  assign busy    = (state_r == ST_RUN) || (state_r == ST_FLUSH);
  assign done    = (state_r == ST_DONE);
  assign err     = err_r;
  assign count   = count_r;

  // Next-state logic for the program sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_RUN;
        else       state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (push_s && in_last) state_s = ST_FLUSH;
        else                   state_s = ST_RUN;
      end
      ST_FLUSH: begin
        // Nothing is pushed here, so the final pop empties the buffer.
        if (pop_s && (occ_r == (PTR_W + 1)'(1))) state_s = ST_DONE;
        else                                      state_s = ST_FLUSH;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Control state, FIFO pointers, write address, word count and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      occ_r   <= {(PTR_W + 1){1'b0}};
      addr_r  <= ADDR_W'(BASE_ADDR);
      count_r <= 16'h0000;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (push_s) wptr_r <= wptr_r + PTR_W'(1);
      if (pop_s)  rptr_r <= rptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + (PTR_W + 1)'(1);
        2'b01:   occ_r <= occ_r - (PTR_W + 1)'(1);
        default: occ_r <= occ_r;
      endcase
      if (begin_s)    addr_r <= ADDR_W'(BASE_ADDR);
      else if (pop_s) addr_r <= addr_r + ADDR_W'(4);
      if (begin_s)                           count_r <= 16'h0000;
      else if (pop_s && count_r != 16'hFFFF) count_r <= count_r + 16'h0001;
      if (begin_s)                 err_r <= 1'b0;
      else if (push_s && enc_s[32]) err_r <= 1'b1;
    end
  end

  // Word storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wptr_r] <= enc_s[31:0];
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0, in_rs1 = 5'd0, in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [6:0]  in_funct7 = 7'd0;
  logic [31:0] in_imm = 32'd0;
  logic        in_last = 1'b0;
  logic        wr_en;
  logic        wr_ready = 1'b0;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, done, err;
  logic [15:0] count;

  instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(12), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoding from the instruction-format rules; returns {error, word}.
  function automatic logic [32:0] ref_enc(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    int          s;
    logic        ok;
    logic [31:0] w;
    s  = $signed(imm);
    ok = 1'b0;
    w  = 32'h0;
    case (f)
      3'd0: begin ok = 1'b1; w = {f7, rs2, rs1, f3, rd, op}; end
      3'd1: begin ok = (s >= -2048 && s <= 2047); w = {imm[11:0], rs1, f3, rd, op}; end
      3'd2: begin ok = (s >= -2048 && s <= 2047); w = {imm[11:5], rs2, rs1, f3, imm[4:0], op}; end
      3'd3: begin
        ok = (s >= -4096 && s <= 4094 && (s % 2) == 0);
        w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      end
      3'd4: begin ok = ((imm % 4096) == 0); w = {imm[31:12], rd, op}; end
      3'd5: begin
        ok = (s >= -1048576 && s <= 1048574 && (s % 2) == 0);
        w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      end
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
  endfunction

  // Reference model state: phase 0 idle, 1 run, 2 flush, 3 done.
  int          m_phase = 0;
  logic [31:0] mq[$];
  logic [11:0] m_addr = 12'd0;
  int          m_count = 0;
  logic        m_err = 1'b0;
  bit          mon_en = 1'b0;
  logic [11:0] log_a[$];
  logic [31:0] log_d[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    logic [32:0] e;
    bit          wr, acc;
    if (mon_en) begin
      chk("wr_en", 32'(wr_en), 32'(mq.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(m_phase == 1 && mq.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("err", 32'(err), 32'(m_err));
      chk("count", 32'(count), 32'(m_count));
      if (mq.size() != 0) begin
        chk("wr_addr", 32'(wr_addr), 32'(m_addr));
        chk("wr_data", wr_data, mq[0]);
      end
      if (done) done_cnt++;
    end
    if (!rst_n) begin
      m_phase = 0; mq.delete(); m_addr = 12'd0; m_count = 0; m_err = 1'b0;
    end else begin
      wr  = (mq.size() != 0) && wr_ready;
      acc = in_valid && m_phase == 1 && mq.size() < DEPTH;
      if (wr) begin
        log_a.push_back(wr_addr);
        log_d.push_back(wr_data);
        void'(mq.pop_front());
        m_addr = m_addr + 12'd4;
        if (m_count < 65535) m_count++;
      end
      if (acc) begin
        e = ref_enc(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        mq.push_back(e[31:0]);
        if (e[32]) m_err = 1'b1;
      end
      case (m_phase)
        0: if (start) begin m_phase = 1; m_count = 0; m_err = 1'b0; m_addr = 12'd0; end
        1: if (acc && in_last) m_phase = 2;
        2: if (wr && mq.size() == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
    end
  end

  bit rnd_ready = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic start_prog();
    log_a.delete(); log_d.delete(); done_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm, input logic last);
    bit acc;
    acc = 1'b0;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 300 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      cyc();
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic rand_req(input logic last);
    logic [31:0] edges [12];
    logic [31:0] imm;
    edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095,
              -32'sd4096, -32'sd4098, 32'd1048574, 32'd1048576, -32'sd1048576, 32'h1234_5000};
    case ($urandom_range(0, 3))
      0:       imm = $urandom;
      1:       imm = 32'($urandom_range(0, 10000)) - 32'd5000;
      2:       imm = edges[$urandom_range(0, 11)];
      default: imm = (32'($urandom_range(0, 4194303)) - 32'd2097152) & 32'hFFFF_FFFE;
    endcase
    req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
        3'($urandom), 7'($urandom), imm, last);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      seen = done;
      cyc();
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n_acc;
    int len;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    cyc();

    // add x3,x1,x2 as a one-word program
    wr_ready = 1'b1;
    start_prog();
    req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    wait_done();
    repeat (3) cyc();
    chk("add_nwr", 32'(log_d.size()), 32'd1);
    chk("add_addr", 32'(log_a[0]), 32'd0);
    chk("add_data", log_d[0], 32'h002081B3);
    chk("add_done_cnt", 32'(done_cnt), 32'd1);
    chk("add_count", 32'(count), 32'd1);

    // addi, beq, jal
    start_prog();
    req(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
    req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4, 1'b0);
    req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1);
    wait_done();
    chk("addi_data", log_d[0], 32'hFFF00293);
    chk("beq_data", log_d[1], 32'hFE208EE3);
    chk("jal_data", log_d[2], 32'h008000EF);
    chk("jal_addr", 32'(log_a[2]), 32'd8);
    chk("addi_err", 32'(err), 32'd0);

    // backpressure: six requests offered against a stalled memory
    wr_ready = 1'b0;
    start_prog();
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      bit a;
      in_fmt = 3'd0; in_opcode = 7'h33; in_rd = 5'(n_acc); in_rs1 = 5'd7; in_rs2 = 5'd9;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_last = (n_acc == 5); in_valid = 1'b1;
      @(negedge clk);
      a = in_ready;
      cyc();
      if (a) n_acc++;
    end
    in_valid = 1'b0;
    chk("bp_accepts", 32'(n_acc), 32'd4);
    wr_ready = 1'b1;
    for (int i = 4; i < 6; i++) req(3'd0, 7'h33, 5'(i), 5'd7, 5'd9, 3'd0, 7'd0, 32'd0, i == 5);
    wait_done();
    chk("bp_nwr", 32'(log_a.size()), 32'd6);
    for (int i = 0; i < 6 && i < log_a.size(); i++) begin
      chk("bp_addr", 32'(log_a[i]), 32'(i * 4));
      chk("bp_rd", 32'(log_d[i][11:7]), 32'(i));
    end

    // out-of-range store immediate
    start_prog();
    req(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd2048, 1'b0);
    req(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
    wait_done();
    chk("s_nop", log_d[0], 32'h0000_0013);
    chk("s_err_sticky", 32'(err), 32'd1);
    start_prog();
    @(negedge clk);
    chk("err_clear", 32'(err), 32'd0);
    cyc();

    // reset while running with three words buffered (program above still in RUN)
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    cyc();
    wr_ready = 1'b1;
    start_prog();
    req(3'd4, 7'h37, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000, 1'b1);
    wait_done();
    chk("post_rst_addr", 32'(log_a[0]), 32'd0);
    chk("lui_data", log_d[0], 32'hABCDE237);

    // random programs with random memory backpressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(1, 12);
      start_prog();
      for (int i = 0; i < len; i++) rand_req(i == len - 1);
      wait_done();
      chk("rnd_nwr", 32'(log_a.size()), 32'(len));
    end

    // long program to wrap the address space
    rnd_ready = 1'b0;
    wr_ready = 1'b1;
    start_prog();
    for (int i = 0; i < 1030; i++) rand_req(i == 1029);
    wait_done();
    chk("wrap_count", 32'(count), 32'd1030);
    chk("wrap_addr", 32'(log_a[1029]), 32'd20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0", 1);
    $fatal(1, "timeout");
  end
endmodule
